// File: rtl/alu_defs_pkg.sv
// -----------------------------------------------------------------------------
// alu_defs_pkg
// Shared encodings for the ALU operation interface: the 4-bit ALU operation
// codes, the instruction opcodes recognised by the issue unit, and the
// funct3/funct7 values used to select an operation. Used by the issue unit,
// its decoder and the ALU itself.
// -----------------------------------------------------------------------------
package alu_defs_pkg;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_OR      = 4'b0010,
        ALU_SLL     = 4'b0011,
        ALU_ILLEGAL = 4'b1111
    } alu_op_e;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
// Purely combinational instruction-field decoder. Maps opcode/funct3/funct7 to
// the ALU operation code, selects whether operand B is the immediate or rs2,
// and flags encodings the ALU path does not support.
//
// Ports:
//   opcode_i   [6:0]  instruction opcode
//   funct3_i   [2:0]  instruction funct3
//   funct7_i   [6:0]  instruction funct7
//   alu_op_o   [3:0]  ALU operation code (ALU_ILLEGAL for unsupported)
//   b_imm_o           1: operand B is the immediate, 0: operand B is rs2
//   illegal_o         encoding is not supported
// -----------------------------------------------------------------------------
module alu_op_decoder
    import alu_defs_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_op_o,
    output logic       b_imm_o,
    output logic       illegal_o
);

    always_comb begin
        alu_op_o  = ALU_ILLEGAL;
        b_imm_o   = 1'b0;
        illegal_o = 1'b1;

        unique case (opcode_i)
            OP_R: begin
                if (funct3_i == F3_ADD_SUB && funct7_i == F7_BASE) begin
                    alu_op_o  = ALU_ADD;
                    illegal_o = 1'b0;
                end else if (funct3_i == F3_ADD_SUB && funct7_i == F7_ALT) begin
                    alu_op_o  = ALU_SUB;
                    illegal_o = 1'b0;
                end else if (funct3_i == F3_OR && funct7_i == F7_BASE) begin
                    alu_op_o  = ALU_OR;
                    illegal_o = 1'b0;
                end else if (funct3_i == F3_SLL && funct7_i == F7_BASE) begin
                    alu_op_o  = ALU_SLL;
                    illegal_o = 1'b0;
                end
            end
            OP_I: begin
                b_imm_o = 1'b1;
                // funct7 only qualifies the shift; ADDI/ORI carry immediate bits there.
                if (funct3_i == F3_ADD_SUB) begin
                    alu_op_o  = ALU_ADD;
                    illegal_o = 1'b0;
                end else if (funct3_i == F3_OR) begin
                    alu_op_o  = ALU_OR;
                    illegal_o = 1'b0;
                end else if (funct3_i == F3_SLL && funct7_i == F7_BASE) begin
                    alu_op_o  = ALU_SLL;
                    illegal_o = 1'b0;
                end
            end
            OP_BR: begin
                // BEQ compares by subtraction; the zero flag reports "taken".
                if (funct3_i == F3_BEQ) begin
                    alu_op_o  = ALU_SUB;
                    illegal_o = 1'b0;
                end
            end
            default: begin
            end
        endcase

        if (illegal_o) begin
            b_imm_o = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
// Initiator side of the ALU operation interface. Accepts decoded instruction
// fields plus operands on a valid/ready request channel, registers the ALU
// operation and operands (issue stage s1) towards a combinational ALU, then
// captures the ALU result and zero flag (response stage s2) and presents them
// on a valid/ready response channel. Full throughput, two register stages.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid_i / req_ready_o  request handshake
//   opcode_i, funct3_i, funct7_i   instruction fields
//   rs1_data_i, rs2_data_i, imm_i  operand sources
//   rd_i                       destination register tag
//   ALU_Operation_o, A_o, B_o  drive to the external ALU
//   ALU_Result_i, Zero_i       combinational return from the ALU
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_result_o, rsp_zero_o, rsp_rd_o, rsp_illegal_o   response payload
// -----------------------------------------------------------------------------
module alu_issue_unit
    import alu_defs_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [4:0]            rd_i,

    output logic [3:0]            ALU_Operation_o,
    output logic [DATA_WIDTH-1:0] A_o,
    output logic [DATA_WIDTH-1:0] B_o,
    input  logic [DATA_WIDTH-1:0] ALU_Result_i,
    input  logic                  Zero_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_result_o,
    output logic                  rsp_zero_o,
    output logic [4:0]            rsp_rd_o,
    output logic                  rsp_illegal_o
);

    logic [3:0] dec_op;
    logic       dec_b_imm;
    logic       dec_illegal;

    alu_op_decoder u_decoder (
        .opcode_i  (opcode_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .alu_op_o  (dec_op),
        .b_imm_o   (dec_b_imm),
        .illegal_o (dec_illegal)
    );

    logic                  s1_valid_q, s1_valid_d;
    logic [3:0]            s1_op_q,    s1_op_d;
    logic [DATA_WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [DATA_WIDTH-1:0] s1_b_q,     s1_b_d;
    logic [4:0]            s1_rd_q,    s1_rd_d;
    logic                  s1_ill_q,   s1_ill_d;

    logic                  rsp_valid_q,  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_zero_q,   rsp_zero_d;
    logic [4:0]            rsp_rd_q,     rsp_rd_d;
    logic                  rsp_ill_q,    rsp_ill_d;

    logic                  s1_adv;
    logic                  accept;
    logic [DATA_WIDTH-1:0] b_sel;
    logic [DATA_WIDTH-1:0] a_issue;
    logic [DATA_WIDTH-1:0] b_issue;

    // s1 drains when s2 is empty or being consumed; the request side sees
    // that same slot, so a new request can land on the edge s1 empties.
    always_comb begin
        s1_adv      = s1_valid_q && (!rsp_valid_q || rsp_ready_i);
        req_ready_o = !reset && (!s1_valid_q || s1_adv);
        accept      = req_valid_i && req_ready_o;
    end

    // Operand selection. Shifts only carry the shift amount so the ALU never
    // sees stray upper immediate/register bits; illegal requests drive zeros.
    always_comb begin
        b_sel   = dec_b_imm ? imm_i : rs2_data_i;
        a_issue = rs1_data_i;
        b_issue = b_sel;
        if (dec_illegal) begin
            a_issue = '0;
            b_issue = '0;
        end else if (dec_op == ALU_SLL) begin
            b_issue = DATA_WIDTH'(b_sel[SHAMT_WIDTH-1:0]);
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_rd_d      = s1_rd_q;
        s1_ill_d     = s1_ill_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_rd_d     = rsp_rd_q;
        rsp_ill_d    = rsp_ill_q;

        // Issue stage: payload only changes on accept, so the ALU drive holds
        // steady under backpressure.
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = dec_op;
            s1_a_d     = a_issue;
            s1_b_d     = b_issue;
            s1_rd_d    = rd_i;
            s1_ill_d   = dec_illegal;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // Response stage
        if (s1_adv) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = ALU_Result_i;
            rsp_zero_d   = Zero_i;
            rsp_rd_d     = s1_rd_q;
            rsp_ill_d    = s1_ill_q;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= ALU_ADD;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_rd_q      <= '0;
            s1_ill_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_rd_q     <= '0;
            rsp_ill_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_rd_q      <= s1_rd_d;
            s1_ill_q     <= s1_ill_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_ill_q    <= rsp_ill_d;
        end
    end

    assign ALU_Operation_o = s1_op_q;
    assign A_o             = s1_a_q;
    assign B_o             = s1_b_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_result_o    = rsp_result_q;
    assign rsp_zero_o      = rsp_zero_q;
    assign rsp_rd_o        = rsp_rd_q;
    assign rsp_illegal_o   = rsp_ill_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_unit
// Scoreboard bench: accepted requests push the expected response (computed
// from instruction semantics) into a queue; a monitor pops and compares on
// every response handshake. An ALU model closes the loop on A_o/B_o.
// -----------------------------------------------------------------------------
module tb_alu_issue_unit;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] BR_OP = 7'b1100011;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rd_i;
    logic [3:0]  ALU_Operation_o;
    logic [31:0] A_o, B_o;
    logic [31:0] ALU_Result_i;
    logic        Zero_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_zero_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_illegal_o;

    alu_issue_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .opcode_i        (opcode_i),
        .funct3_i        (funct3_i),
        .funct7_i        (funct7_i),
        .rs1_data_i      (rs1_data_i),
        .rs2_data_i      (rs2_data_i),
        .imm_i           (imm_i),
        .rd_i            (rd_i),
        .ALU_Operation_o (ALU_Operation_o),
        .A_o             (A_o),
        .B_o             (B_o),
        .ALU_Result_i    (ALU_Result_i),
        .Zero_i          (Zero_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_result_o    (rsp_result_o),
        .rsp_zero_o      (rsp_zero_o),
        .rsp_rd_o        (rsp_rd_o),
        .rsp_illegal_o   (rsp_illegal_o)
    );

    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (ALU_Operation_o)
            4'b0000: ALU_Result_i = A_o + B_o;
            4'b0001: ALU_Result_i = A_o - B_o;
            4'b0010: ALU_Result_i = A_o | B_o;
            4'b0011: ALU_Result_i = A_o << B_o[4:0];
            default: ALU_Result_i = 32'd0;
        endcase
        Zero_i = (ALU_Result_i == 32'd0);
    end

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          rsp_cnt = 0;
    int          stalls = 0;
    int          cyc = 0;
    int          rsp_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: what the instruction means, independent of any encoding
    // inside the unit.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm,
                                   input logic [4:0] rd);
        exp_t e;
        logic ok;
        logic [31:0] r;
        ok = 1'b1;
        r  = 32'd0;
        if (opc == R_OP && f3 == 3'd0 && f7 == 7'h00)      r = rs1 + rs2;
        else if (opc == R_OP && f3 == 3'd0 && f7 == 7'h20) r = rs1 - rs2;
        else if (opc == R_OP && f3 == 3'd6 && f7 == 7'h00) r = rs1 | rs2;
        else if (opc == R_OP && f3 == 3'd1 && f7 == 7'h00) r = rs1 << (rs2 % 32);
        else if (opc == I_OP && f3 == 3'd0)                r = rs1 + imm;
        else if (opc == I_OP && f3 == 3'd6)                r = rs1 | imm;
        else if (opc == I_OP && f3 == 3'd1 && f7 == 7'h00) r = rs1 << (imm % 32);
        else if (opc == BR_OP && f3 == 3'd0)               r = rs1 - rs2;
        else ok = 1'b0;
        e.result = r;
        e.zero   = (r == 32'd0);
        e.rd     = rd;
        e.ill    = !ok;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs change only just after posedge, so what is seen here is
    // what the next edge will act on.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_cnt++;
                rsp_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=result 0x%0h rd %0d required=no response",
                             rsp_result_o, rsp_rd_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_payload", 64'({rsp_result_o, rsp_zero_o, rsp_rd_o, rsp_illegal_o}), 64'(e));
                end
            end
            if (req_valid_i && req_ready_o)
                sb.push_back(model(opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i, imm_i, rd_i));
        end
    end

    // Presents one request and holds it until accepted; returns 1 time unit
    // after the accepting edge.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd);
        int n;
        opcode_i = opc; funct3_i = f3; funct7_i = f7;
        rs1_data_i = rs1; rs2_data_i = rs2; imm_i = imm; rd_i = rd;
        req_valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 100) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (!req_ready_o) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not accepted required=accepted within 100 cycles");
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid_o) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic        done;
    logic [31:0] rnd, rnd2;
    logic [3:0]  hold_op;
    logic [31:0] hold_a, hold_b, hold_res;
    logic        hold_rv;
    int          base_cnt;

    initial begin
        reset = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        opcode_i = '0; funct3_i = '0; funct7_i = '0;
        rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; rd_i = '0;
        done = 1'b0;
        repeat (3) step();

        // Reset state
        check("reset_req_ready", 64'(req_ready_o), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("reset_alu_op", 64'(ALU_Operation_o), 64'd0);
        check("reset_a_b", 64'({A_o, B_o}), 64'd0);
        check("reset_rsp_payload", 64'({rsp_result_o, rsp_zero_o, rsp_rd_o, rsp_illegal_o}), 64'd0);
        reset = 1'b0;
        step();

        // ADDI latency: not valid after accept edge, valid after the next one
        send(I_OP, 3'd0, 7'h7f, 32'd5, 32'd0, 32'hFFFF_FFF9, 5'd3);
        check("addi_rsp_early", 64'(rsp_valid_o), 64'd0);
        step();
        check("addi_rsp_valid", 64'(rsp_valid_o), 64'd1);
        check("addi_result", 64'(rsp_result_o), 64'hFFFF_FFFE);
        drain();

        // BEQ taken / not taken
        send(BR_OP, 3'd0, 7'h00, 32'h1234, 32'h1234, 32'd0, 5'd0);
        check("beq_alu_op", 64'(ALU_Operation_o), 64'd1);
        send(BR_OP, 3'd0, 7'h00, 32'h1234, 32'h1235, 32'd0, 5'd0);
        drain();

        // Shift amounts come from the low five bits only
        send(I_OP, 3'd1, 7'h00, 32'd1, 32'd0, 32'h25, 5'd4);
        send(R_OP, 3'd1, 7'h00, 32'd1, 32'hFFFF_FFE3, 32'd0, 5'd5);
        drain();

        // Back-to-back stream with no bubbles
        stalls = 0;
        rsp_cyc.delete();
        send(R_OP, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0, 5'd1);
        send(R_OP, 3'd6, 7'h00, 32'hF0, 32'h0F, 32'd0, 5'd2);
        send(R_OP, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 5'd3);
        send(R_OP, 3'd1, 7'h00, 32'd3, 32'd2, 32'd0, 5'd4);
        drain();
        check("stream_stalls", 64'(stalls), 64'd0);
        check("stream_rsp_count", 64'(rsp_cyc.size()), 64'd4);
        if (rsp_cyc.size() == 4)
            for (int i = 0; i < 3; i++)
                check("stream_rsp_spacing", 64'(rsp_cyc[i+1] - rsp_cyc[i]), 64'd1);

        // Backpressure: three requests offered, two fit, everything holds
        base_cnt = rsp_cnt;
        rsp_ready_i = 1'b0;
        fork
            begin
                send(R_OP, 3'd0, 7'h00, 32'd100, 32'd1, 32'd0, 5'd10);
                send(R_OP, 3'd6, 7'h00, 32'h100, 32'h1, 32'd0, 5'd11);
                send(I_OP, 3'd0, 7'h00, 32'd7, 32'd0, 32'd8, 5'd12);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("bp_req_ready", 64'(req_ready_o), 64'd0);
                hold_op = ALU_Operation_o; hold_a = A_o; hold_b = B_o;
                hold_res = rsp_result_o; hold_rv = rsp_valid_o;
                @(negedge clk);
                check("bp_hold_alu", 64'({ALU_Operation_o, A_o}), 64'({hold_op, hold_a}));
                check("bp_hold_b", 64'(B_o), 64'(hold_b));
                check("bp_hold_rsp", 64'({rsp_valid_o, rsp_result_o}), 64'({hold_rv, hold_res}));
                @(posedge clk);
                #1 rsp_ready_i = 1'b1;
            end
        join
        drain();
        check("bp_delivered", 64'(rsp_cnt - base_cnt), 64'd3);

        // Illegal opcode
        send(7'b0000000, 3'd0, 7'h00, 32'hDEAD, 32'hBEEF, 32'd1, 5'd9);
        drain();

        // Reset with both stages full
        rsp_ready_i = 1'b0;
        send(R_OP, 3'd0, 7'h00, 32'd1, 32'd2, 32'd0, 5'd20);
        send(R_OP, 3'd0, 7'h00, 32'd3, 32'd4, 32'd0, 5'd21);
        reset = 1'b1;
        step();
        check("rst_mid_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_mid_alu_op", 64'(ALU_Operation_o), 64'd0);
        check("rst_mid_req_ready", 64'(req_ready_o), 64'd0);
        base_cnt = rsp_cnt;
        reset = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (4) step();
        check("rst_no_stale", 64'(rsp_cnt - base_cnt), 64'd0);

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [6:0] opc, f7;
                    logic [2:0] f3;
                    logic [31:0] a, b;
                    rnd = $urandom;
                    rnd2 = $urandom;
                    case (rnd[1:0])
                        2'd0: opc = R_OP;
                        2'd1: opc = I_OP;
                        2'd2: opc = BR_OP;
                        default: opc = rnd2[6:0];
                    endcase
                    case (rnd[3:2])
                        2'd0: f3 = 3'd0;
                        2'd1: f3 = 3'd1;
                        2'd2: f3 = 3'd6;
                        default: f3 = rnd2[9:7];
                    endcase
                    case (rnd[5:4])
                        2'd0, 2'd1: f7 = 7'h00;
                        2'd2: f7 = 7'h20;
                        default: f7 = rnd2[16:10];
                    endcase
                    a = $urandom;
                    b = rnd[6] ? a : $urandom;
                    if (rnd[7]) a = {28'd0, a[3:0]};
                    send(opc, f3, f7, a, b, $urandom, rnd[12:8]);
                    if (rnd[15:13] == 3'd0) step();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    rnd = $urandom;
                    #1 rsp_ready_i = (rnd[1:0] != 2'd0);
                end
            end
        join
        rsp_ready_i = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
